// File: rtl/alu_ctrl_defs.sv
// -----------------------------------------------------------------------------
// alu_ctrl_defs
// Shared definitions for the ALU command sequencer:
//   - command codes presented on in_cmd (0..5 legal, 6/7 illegal)
//   - ALU op encodings {Binvert, Sel1, Sel0} driven on alu_op
//   - sequencer FSM state encodings
//   - small decode helpers used by the sequencer
// No ports (package).
// -----------------------------------------------------------------------------
package alu_ctrl_defs;

   // Command codes
   localparam logic [2:0] CMD_AND  = 3'd0;
   localparam logic [2:0] CMD_OR   = 3'd1;
   localparam logic [2:0] CMD_ADD  = 3'd2;
   localparam logic [2:0] CMD_SUB  = 3'd3;
   localparam logic [2:0] CMD_SLT  = 3'd4;
   localparam logic [2:0] CMD_MULU = 3'd5;

   // ALU op codes {Binvert, Sel1, Sel0}
   localparam logic [2:0] OP_AND = 3'b000;
   localparam logic [2:0] OP_OR  = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_SUB = 3'b110;
   localparam logic [2:0] OP_SLT = 3'b111;

   // Sequencer states
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_MUL  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   // ALU op for a single-cycle command; MULU and illegal codes map to AND,
   // which is also the quiet value driven outside EXEC.
   function automatic logic [2:0] cmd_to_op(input logic [2:0] cmd);
      logic [2:0] op;
      op = OP_AND;
      case (cmd)
         CMD_AND: op = OP_AND;
         CMD_OR:  op = OP_OR;
         CMD_ADD: op = OP_ADD;
         CMD_SUB: op = OP_SUB;
         CMD_SLT: op = OP_SLT;
         default: op = OP_AND;
      endcase
      return op;
   endfunction

   function automatic logic cmd_is_legal(input logic [2:0] cmd);
      return (cmd <= CMD_MULU);
   endfunction

   // Only ADD and SUB report signed overflow.
   function automatic logic cmd_has_ovf(input logic [2:0] cmd);
      return (cmd == CMD_ADD) || (cmd == CMD_SUB);
   endfunction

endpackage

// File: rtl/mul_step_datapath.sv
// -----------------------------------------------------------------------------
// mul_step_datapath
// Shift-add unsigned multiplier state: HI/LO product registers and the
// iteration counter. The addition itself is done by the shared ALU; this block
// feeds HI to the ALU (the top routes it to alu_a) and merges the ALU sum and
// carry back into {HI,LO} with a one-bit right shift each step.
//
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   start        load HI=0, LO=load_b, cnt=0 (command accept edge)
//   step         perform one iteration this cycle (FSM in MUL)
//   load_b       multiplier value loaded into LO on start
//   alu_r        ALU sum of HI + multiplicand
//   alu_cout     ALU carry out of that sum
//   hi           current HI register (ALU A operand during MUL)
//   hi_nxt       HI value after this cycle's iteration
//   lo_nxt       LO value after this cycle's iteration
//   done         high during the last iteration (cnt == WIDTH-1)
// -----------------------------------------------------------------------------
module mul_step_datapath #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             step,
   input  logic [WIDTH-1:0] load_b,
   input  logic [WIDTH-1:0] alu_r,
   input  logic             alu_cout,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] hi_nxt,
   output logic [WIDTH-1:0] lo_nxt,
   output logic             done
);

   logic [WIDTH-1:0] lo;
   logic [CNT_W-1:0] cnt;

   // One iteration: when the multiplier LSB is set the ALU sum (with its
   // carry as the new MSB) replaces HI before the shift; otherwise HI is
   // shifted as-is with a zero entering from the top.
   always_comb begin
      hi_nxt = {1'b0, hi[WIDTH-1:1]};
      lo_nxt = {hi[0], lo[WIDTH-1:1]};
      if (lo[0]) begin
         hi_nxt = {alu_cout, alu_r[WIDTH-1:1]};
         lo_nxt = {alu_r[0], lo[WIDTH-1:1]};
      end
   end

   assign done = step && (cnt == CNT_W'(WIDTH - 1));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         hi  <= '0;
         lo  <= '0;
         cnt <= '0;
      end else if (start) begin
         hi  <= '0;
         lo  <= load_b;
         cnt <= '0;
      end else if (step) begin
         hi  <= hi_nxt;
         lo  <= lo_nxt;
         cnt <= cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/alu_op_sequencer.sv
// -----------------------------------------------------------------------------
// alu_op_sequencer
// Command-level controller in front of a shared combinational ALU. Accepts one
// command at a time, drives ALU operands/op, and returns a result word pair.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. in_ready is high only in IDLE; in_valid outside IDLE is ignored.
// out_valid is high only in DONE, and all out_* values stay stable until the
// edge where out_ready is high.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   in_valid/in_ready   command handshake
//   in_cmd              0 AND, 1 OR, 2 ADD, 3 SUB, 4 SLT, 5 MULU, 6/7 illegal
//   in_a, in_b          operands (A = multiplicand, B = multiplier for MULU)
//   alu_a, alu_b, alu_op  ALU drive
//   alu_r, alu_cout, alu_v  ALU result, carry out, signed overflow
//   out_valid/out_ready result handshake
//   out_lo, out_hi      result / product low word, product high word
//   out_v               signed overflow (ADD/SUB only)
//   out_err             illegal command flag
//   busy                high whenever not IDLE
// -----------------------------------------------------------------------------
import alu_ctrl_defs::*;

module alu_op_sequencer #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       in_cmd,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [2:0]       alu_op,
   input  logic [WIDTH-1:0] alu_r,
   input  logic             alu_cout,
   input  logic             alu_v,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_lo,
   output logic [WIDTH-1:0] out_hi,
   output logic             out_v,
   output logic             out_err,
   output logic             busy
);

   state_t           state_q, state_d;
   logic [2:0]       cmd_q;
   logic [WIDTH-1:0] a_q, b_q;

   logic             mul_start, mul_step, mul_done;
   logic [WIDTH-1:0] mul_hi, mul_hi_nxt, mul_lo_nxt;

   mul_step_datapath #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) u_mul (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (mul_start),
      .step     (mul_step),
      .load_b   (in_b),
      .alu_r    (alu_r),
      .alu_cout (alu_cout),
      .hi       (mul_hi),
      .hi_nxt   (mul_hi_nxt),
      .lo_nxt   (mul_lo_nxt),
      .done     (mul_done)
   );

   // Next state and ALU drive
   always_comb begin
      state_d   = state_q;
      alu_a     = a_q;
      alu_b     = b_q;
      alu_op    = OP_AND;
      mul_start = 1'b0;
      mul_step  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               if (in_cmd == CMD_MULU) begin
                  state_d   = S_MUL;
                  mul_start = 1'b1;
               end else if (cmd_is_legal(in_cmd)) begin
                  state_d = S_EXEC;
               end else begin
                  state_d = S_DONE;
               end
            end
         end
         S_EXEC: begin
            alu_op  = cmd_to_op(cmd_q);
            state_d = S_DONE;
         end
         S_MUL: begin
            // ALU computes HI + multiplicand for this iteration.
            alu_a    = mul_hi;
            alu_b    = a_q;
            alu_op   = OP_ADD;
            mul_step = 1'b1;
            if (mul_done) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign in_ready  = (state_q == S_IDLE);
   assign busy      = (state_q != S_IDLE);
   assign out_valid = (state_q == S_DONE);

   // State, captured command and result registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cmd_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         out_lo  <= '0;
         out_hi  <= '0;
         out_v   <= 1'b0;
         out_err <= 1'b0;
      end else begin
         state_q <= state_d;
         case (state_q)
            S_IDLE: begin
               if (in_valid) begin
                  cmd_q <= in_cmd;
                  a_q   <= in_a;
                  b_q   <= in_b;
                  // Illegal commands skip execution, so their result is
                  // finalised right at the accept edge.
                  if (!cmd_is_legal(in_cmd)) begin
                     out_lo  <= '0;
                     out_hi  <= '0;
                     out_v   <= 1'b0;
                     out_err <= 1'b1;
                  end
               end
            end
            S_EXEC: begin
               out_lo  <= alu_r;
               out_hi  <= '0;
               out_v   <= cmd_has_ovf(cmd_q) ? alu_v : 1'b0;
               out_err <= 1'b0;
            end
            S_MUL: begin
               // Load the post-iteration values so the final step lands in
               // the result registers on the same edge that enters DONE.
               if (mul_done) begin
                  out_lo  <= mul_lo_nxt;
                  out_hi  <= mul_hi_nxt;
                  out_v   <= 1'b0;
                  out_err <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_op_sequencer.sv
module tb_alu_op_sequencer;

   localparam int WIDTH = 32;

   // ---------------------------------------------------------------- clock/reset
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // ---------------------------------------------------------------- signals
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [2:0]       in_cmd = 3'd0;
   logic [WIDTH-1:0] in_a = '0;
   logic [WIDTH-1:0] in_b = '0;
   logic [WIDTH-1:0] alu_a, alu_b, alu_r;
   logic [2:0]       alu_op;
   logic             alu_cout, alu_v;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [WIDTH-1:0] out_lo, out_hi;
   logic             out_v, out_err, busy;

   // ---------------------------------------------------------------- ALU model
   // Ripple ALU behaviour: Binvert inverts B and injects carry-in 1;
   // Sel selects AND / OR / SUM / SLT (Set = sign of A-B, overflow corrected).
   logic [WIDTH-1:0] m_bb;
   logic [WIDTH:0]   m_sum;
   always_comb begin
      m_bb     = alu_op[2] ? ~alu_b : alu_b;
      m_sum    = {1'b0, alu_a} + {1'b0, m_bb} + {{WIDTH{1'b0}}, alu_op[2]};
      alu_cout = m_sum[WIDTH];
      alu_v    = (alu_a[WIDTH-1] == m_bb[WIDTH-1]) && (m_sum[WIDTH-1] != alu_a[WIDTH-1]);
      case (alu_op[1:0])
         2'b00:   alu_r = alu_a & m_bb;
         2'b01:   alu_r = alu_a | m_bb;
         2'b10:   alu_r = m_sum[WIDTH-1:0];
         default: alu_r = {{(WIDTH-1){1'b0}}, m_sum[WIDTH-1] ^ alu_v};
      endcase
   end

   // ---------------------------------------------------------------- DUT
   alu_op_sequencer #(.WIDTH(WIDTH), .CNT_W(6)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_cmd    (in_cmd),
      .in_a      (in_a),
      .in_b      (in_b),
      .alu_a     (alu_a),
      .alu_b     (alu_b),
      .alu_op    (alu_op),
      .alu_r     (alu_r),
      .alu_cout  (alu_cout),
      .alu_v     (alu_v),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_lo    (out_lo),
      .out_hi    (out_hi),
      .out_v     (out_v),
      .out_err   (out_err),
      .busy      (busy)
   );

   // ---------------------------------------------------------------- scoreboard
   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
   endtask

   typedef struct {
      logic [2:0]       cmd;
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic [WIDTH-1:0] lo;
      logic [WIDTH-1:0] hi;
      logic             v;
      logic             err;
      logic [2:0]       op1;   // alu_op in the cycle after accept
      int               lat;   // cycle of first out_valid (accept edge = 0)
   } vec_t;

   localparam int NVEC = 18;
   vec_t vecs[NVEC];

   // ---------------------------------------------------------------- driver
   // Present a command, record latency, check results, then complete the
   // output handshake and check the return to IDLE.
   task automatic run_vec(input vec_t t, input int idx);
      int cyc;
      @(negedge clk);
      in_cmd   = t.cmd;
      in_a     = t.a;
      in_b     = t.b;
      in_valid = 1'b1;
      check($sformatf("v%0d in_ready_idle", idx), in_ready, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      cyc = 1;
      check($sformatf("v%0d alu_op_c1", idx), alu_op, t.op1);
      check($sformatf("v%0d busy_c1", idx), busy, 1);
      while (!out_valid && cyc < 100) begin
         @(posedge clk); #1;
         cyc++;
      end
      check($sformatf("v%0d latency", idx), cyc, t.lat);
      check($sformatf("v%0d out_lo", idx), out_lo, t.lo);
      check($sformatf("v%0d out_hi", idx), out_hi, t.hi);
      check($sformatf("v%0d out_v", idx), out_v, t.v);
      check($sformatf("v%0d out_err", idx), out_err, t.err);
      check($sformatf("v%0d in_ready_done", idx), in_ready, 0);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check($sformatf("v%0d out_valid_after", idx), out_valid, 0);
      check($sformatf("v%0d in_ready_after", idx), in_ready, 1);
   endtask

   // ---------------------------------------------------------------- test
   initial begin
      vecs[0]  = '{3'd0, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 32'h0, 1'b0, 1'b0, 3'b000, 2};
      vecs[1]  = '{3'd1, 32'hF000_0001, 32'h0000_0010, 32'hF000_0011, 32'h0, 1'b0, 1'b0, 3'b001, 2};
      vecs[2]  = '{3'd2, 32'd5,         32'd7,         32'd12,        32'h0, 1'b0, 1'b0, 3'b010, 2};
      vecs[3]  = '{3'd2, 32'h7FFF_FFFF, 32'd1,         32'h8000_0000, 32'h0, 1'b1, 1'b0, 3'b010, 2};
      vecs[4]  = '{3'd2, 32'hFFFF_FFFF, 32'd1,         32'h0,         32'h0, 1'b0, 1'b0, 3'b010, 2};
      vecs[5]  = '{3'd3, 32'h8000_0000, 32'd1,         32'h7FFF_FFFF, 32'h0, 1'b1, 1'b0, 3'b110, 2};
      vecs[6]  = '{3'd3, 32'd10,        32'd3,         32'd7,         32'h0, 1'b0, 1'b0, 3'b110, 2};
      vecs[7]  = '{3'd4, 32'hFFFF_FFFF, 32'd1,         32'd1,         32'h0, 1'b0, 1'b0, 3'b111, 2};
      vecs[8]  = '{3'd4, 32'd1,         32'hFFFF_FFFF, 32'd0,         32'h0, 1'b0, 1'b0, 3'b111, 2};
      vecs[9]  = '{3'd4, 32'h8000_0000, 32'd1,         32'd1,         32'h0, 1'b0, 1'b0, 3'b111, 2};
      vecs[10] = '{3'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0, 1'b0, 3'b010, 33};
      vecs[11] = '{3'd5, 32'd3,         32'd0,         32'h0,         32'h0, 1'b0, 1'b0, 3'b010, 33};
      vecs[12] = '{3'd5, 32'h0001_0000, 32'h0001_0000, 32'h0,         32'h1, 1'b0, 1'b0, 3'b010, 33};
      vecs[13] = '{3'd5, 32'd12345,     32'd1000,      32'h00BC_5EA8, 32'h0, 1'b0, 1'b0, 3'b010, 33};
      vecs[14] = '{3'd6, 32'd5,         32'd7,         32'h0,         32'h0, 1'b0, 1'b1, 3'b000, 1};
      vecs[15] = '{3'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,         32'h0, 1'b0, 1'b1, 3'b000, 1};
      vecs[16] = '{3'd2, 32'h100,       32'h200,       32'h300,       32'h0, 1'b0, 1'b0, 3'b010, 2};
      vecs[17] = '{3'd2, 32'h10,        32'h20,        32'h30,        32'h0, 1'b0, 1'b0, 3'b010, 2};

      // Reset state
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst in_ready", in_ready, 1);
      check("rst busy", busy, 0);
      check("rst out_valid", out_valid, 0);
      check("rst out_lo", out_lo, 0);
      check("rst out_hi", out_hi, 0);
      check("rst out_v_err", {out_v, out_err}, 0);
      check("rst alu_drive", {alu_a, alu_b, alu_op}, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Table-driven vectors
      for (int i = 0; i < NVEC; i++) run_vec(vecs[i], i);

      // Backpressure: result held 5 cycles while a new command is offered.
      @(negedge clk);
      in_cmd = 3'd2; in_a = 32'h10; in_b = 32'h20; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      check("bp valid_at_c2", out_valid, 1);
      in_cmd = 3'd3; in_a = 32'h999; in_b = 32'h1; in_valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         check($sformatf("bp%0d out_valid", k), out_valid, 1);
         check($sformatf("bp%0d out_lo", k), out_lo, 32'h30);
         check($sformatf("bp%0d out_hi_v_err", k), {out_hi, out_v, out_err}, 0);
         check($sformatf("bp%0d in_ready", k), in_ready, 0);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("bp release in_ready", in_ready, 1);
      check("bp release out_valid", out_valid, 0);
      check("bp release out_lo_held", out_lo, 32'h30);

      // Reset during multiply at cnt=10
      @(negedge clk);
      in_cmd = 3'd5; in_a = 32'hFFFF_FFFF; in_b = 32'h0001_2345; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (10) begin @(posedge clk); #1; end
      check("mrst busy_before", busy, 1);
      check("mrst alu_op_mul", alu_op, 3'b010);
      rst_n = 1'b0;
      @(posedge clk); #1;
      check("mrst in_ready", in_ready, 1);
      check("mrst busy", busy, 0);
      check("mrst out_valid", out_valid, 0);
      check("mrst out_lo", out_lo, 0);
      check("mrst out_hi", out_hi, 0);
      check("mrst out_v_err", {out_v, out_err}, 0);
      check("mrst alu_drive", {alu_a, alu_b, alu_op}, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Recovery after reset
      run_vec(vecs[2], 100);
      run_vec(vecs[10], 101);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   // Global watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
